// File: rtl/mem_seq.sv
// Sequencer for a shared SRAM port: round-robin arbitration between an
// instruction-fetch and a data requester, then a timed read or write cycle.
module mem_seq #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic F_REQ,
    input  logic D_REQ,
    input  logic D_WE,
    output logic GNT_F,
    output logic GNT_D,
    output logic DONE_F,
    output logic DONE_D,
    output logic LD_MAR,
    output logic LD_MDR,
    output logic MIO_EN,
    output logic Mem_OE_N,
    output logic Mem_WE_N,
    output logic BUSY
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_RWAIT,
        S_RLATCH,
        S_WRITE,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               winner_q, winner_d;   // 1 = data requester owns the bus
    logic               we_q, we_d;
    logic               last_q, last_d;       // 1 = data was served last

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            winner_q <= 1'b0;
            we_q     <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            winner_q <= winner_d;
            we_q     <= we_d;
            last_q   <= last_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        winner_d = winner_q;
        we_d     = we_q;
        last_d   = last_q;
        case (state_q)
            S_IDLE: begin
                if (F_REQ || D_REQ) begin
                    // Data wins if alone, or if both ask and fetch went last
                    winner_d = D_REQ && (!F_REQ || !last_q);
                    we_d     = winner_d && D_WE;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                cnt_d   = CNT_LOAD;
                state_d = we_q ? S_WDATA : S_RWAIT;
            end
            S_WDATA: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WRITE;
            end
            S_RWAIT: begin
                if (cnt_q == '0) state_d = S_RLATCH;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_RLATCH: state_d = S_DONE;
            S_WRITE: begin
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_DONE: begin
                last_d  = winner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode
    always_comb begin
        LD_MAR   = 1'b0;
        LD_MDR   = 1'b0;
        MIO_EN   = 1'b0;
        Mem_OE_N = 1'b1;
        Mem_WE_N = 1'b1;
        DONE_F   = 1'b0;
        DONE_D   = 1'b0;
        BUSY     = (state_q != S_IDLE);
        GNT_F    = BUSY && !winner_q;
        GNT_D    = BUSY && winner_q;
        case (state_q)
            S_ADDR:   LD_MAR = 1'b1;
            S_WDATA:  LD_MDR = 1'b1;
            S_RWAIT:  Mem_OE_N = 1'b0;
            S_RLATCH: begin
                Mem_OE_N = 1'b0;
                LD_MDR   = 1'b1;
                MIO_EN   = 1'b1;
            end
            S_WRITE:  Mem_WE_N = 1'b0;
            S_DONE: begin
                DONE_F = !winner_q;
                DONE_D = winner_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_seq.md
MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning SRAM read and write wait states; legal range 1..15.
REQ-002 SHALL have port Clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port F_REQ, input, 1, instruction-fetch read request.
REQ-005 SHALL have port D_REQ, input, 1, data-access request.
REQ-006 SHALL have port D_WE, input, 1, data access is a write (1) or read (0); sampled at grant.
REQ-007 SHALL have ports GNT_F and GNT_D, output, 1 each, bus ownership grant to the fetch or data requester.
REQ-008 SHALL have ports DONE_F and DONE_D, output, 1 each, one-cycle completion pulse per requester.
REQ-009 SHALL have ports LD_MAR, LD_MDR, MIO_EN, output, 1 each, MAR/MDR load and MDR source select (1 = memory).
REQ-010 SHALL have ports Mem_OE_N and Mem_WE_N, output, 1 each, active-low SRAM output and write enables.
REQ-011 SHALL have port BUSY, output, 1, high in every state except IDLE.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, ADDR, WDATA, RWAIT, RLATCH, WRITE, DONE; all outputs decoded from state only.
REQ-013 IDLE: no request -> stay; any request -> ADDR, latching winner and, for data, D_WE.
REQ-014 Arbitration SHALL be round-robin: if both request, grant the requester not served last; a lone requester is always granted.
REQ-015 ADDR: LD_MAR=1, winner's GNT=1 (requester drives address on BUS); next is WDATA if write, else RWAIT.
REQ-016 WDATA: LD_MDR=1, MIO_EN=0 (MDR loads BUS write data); next WRITE.
REQ-017 RWAIT: Mem_OE_N=0 for exactly WAIT_CYCLES cycles via a 4-bit down-counter loaded on entry; then RLATCH.
REQ-018 RLATCH: Mem_OE_N=0, LD_MDR=1, MIO_EN=1 (MDR loads memory data); next DONE.
REQ-019 WRITE: Mem_WE_N=0 for exactly WAIT_CYCLES cycles; Mem_OE_N stays 1; then DONE.
REQ-020 DONE: winner's DONE pulse=1 for one cycle, last-served pointer updated; next IDLE unconditionally.
REQ-021 GNT of the winner SHALL stay high from ADDR through DONE inclusive; the other GNT stays 0.
REQ-022 Read latency: grant-to-DONE = WAIT_CYCLES+3 cycles; write latency = WAIT_CYCLES+3 cycles.
REQ-023 Requests SHALL be held by requesters until DONE; deassertion mid-operation SHALL be ignored and the operation completes.
REQ-024 Mem_OE_N and Mem_WE_N SHALL never be low in the same cycle; LD_MDR SHALL never be high with Mem_WE_N low.
REQ-025 A request held through DONE SHALL be re-arbitrated in the following IDLE cycle (minimum one IDLE cycle between operations).
REQ-026 D_WE changes after grant SHALL NOT affect the operation in progress.

Reset
REQ-027 Reset high at a rising edge SHALL force IDLE, counter 0, last-served = data, regardless of current state.
REQ-028 During and after reset: LD_MAR=LD_MDR=MIO_EN=0, Mem_OE_N=Mem_WE_N=1, GNT_*=0, DONE_*=0, BUSY=0.
REQ-029 Reset mid-operation SHALL abort without a DONE pulse; the first post-reset arbitration with both requests grants fetch.

Verification
REQ-030 WAIT_CYCLES=2, F_REQ alone -> ADDR(LD_MAR), 2 cycles OE_N=0, RLATCH(LD_MDR, MIO_EN=1), DONE_F pulse 5 cycles after request sampled.
REQ-031 D_REQ=1, D_WE=1 -> ADDR, WDATA(LD_MDR, MIO_EN=0), WE_N=0 for 2 cycles, DONE_D; OE_N stays 1 throughout.
REQ-032 F_REQ and D_REQ held high continuously after reset -> grants alternate F, D, F, D with one IDLE cycle between each.
REQ-033 Reset asserted during RWAIT -> next cycle all outputs at reset values, no DONE_F, BUSY=0.
REQ-034 WAIT_CYCLES=15 read; F_REQ dropped in RWAIT -> OE_N low exactly 15 cycles, DONE_F still pulses.
REQ-035 D_WE toggled 0->1 during RWAIT of a data read -> operation remains a read, WE_N never low.
